// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator.
// One brightness level is shared by all channels. It is shaped by one of four
// modes (off, steady, blink, breathe), turned into PWM, and sent to CHANNELS
// outputs. Each output has its own enable and its own polarity.
module led_pattern_gen #(
   parameter int                  CLK_HZ      = 12000000,
   parameter int                  TICK_HZ     = 1000,
   parameter int                  PWM_BITS    = 8,
   parameter int                  CHANNELS    = 3,
   parameter int                  BLINK_TICKS = 500,
   parameter logic [CHANNELS-1:0] INVERT_MASK = '0
) (
   input  logic                i_Clk,
   input  logic                i_Rst,
   input  logic [1:0]          i_Mode,
   input  logic [PWM_BITS-1:0] i_Brightness,
   input  logic                i_Load,
   input  logic [CHANNELS-1:0] i_Chan_En,
   output logic [CHANNELS-1:0] o_Led,
   output logic [1:0]          o_Mode,
   output logic [PWM_BITS-1:0] o_Level
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BW  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

   localparam logic [1:0] MODE_OFF     = 2'd0;
   localparam logic [1:0] MODE_ON      = 2'd1;
   localparam logic [1:0] MODE_BLINK   = 2'd2;
   localparam logic [1:0] MODE_BREATHE = 2'd3;

   // Breathe direction FSM states
   localparam logic [0:0] DIR_UP   = 1'b0;
   localparam logic [0:0] DIR_DOWN = 1'b1;

   logic [PW-1:0]       presc;
   logic                tick;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [1:0]          mode;
   logic [PWM_BITS-1:0] bright;
   logic [PWM_BITS-1:0] level;
   logic [BW-1:0]       blink_cnt;
   logic                phase;
   logic [0:0]          dir;
   logic                duty_on;
   logic [CHANNELS-1:0] led;

   assign tick    = (presc == PW'(DIV - 1));
   assign duty_on = (pwm_cnt < level);

   // Step-rate prescaler. A load restarts it so the pattern timing begins at the load.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst)
         presc <= '0;
      else if (i_Load || tick)
         presc <= '0;
      else
         presc <= presc + 1'b1;
   end

   // Free-running PWM counter. It is realigned on a load.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst)
         pwm_cnt <= '0;
      else if (i_Load)
         pwm_cnt <= '0;
      else
         pwm_cnt <= pwm_cnt + 1'b1;
   end

   // Pattern state: a load latches the settings, and every tick advances the level.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         mode      <= MODE_OFF;
         bright    <= '0;
         level     <= '0;
         blink_cnt <= '0;
         phase     <= 1'b0;
         dir       <= DIR_UP;
      end else if (i_Load) begin
         mode      <= i_Mode;
         bright    <= i_Brightness;
         blink_cnt <= '0;
         phase     <= 1'b1;
         dir       <= DIR_UP;
         case (i_Mode)
            MODE_ON, MODE_BLINK: level <= i_Brightness;
            default:             level <= '0;
         endcase
      end else if (tick) begin
         case (mode)
            MODE_OFF: level <= '0;
            MODE_ON:  level <= bright;
            MODE_BLINK: begin
               if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
                  blink_cnt <= '0;
                  phase     <= ~phase;
                  // phase still holds its old value here, so the new phase is its inverse
                  level     <= phase ? '0 : bright;
               end else begin
                  blink_cnt <= blink_cnt + 1'b1;
               end
            end
            MODE_BREATHE: begin
               if (dir == DIR_UP) begin
                  if (level < bright)
                     level <= level + 1'b1;
                  else
                     dir <= DIR_DOWN;
               end else begin
                  if (level > '0)
                     level <= level - 1'b1;
                  else
                     dir <= DIR_UP;
               end
            end
            default: level <= '0;
         endcase
      end
   end

   // Registered LED drive. A disabled channel sits at its inactive polarity.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst)
         led <= INVERT_MASK;
      else
         led <= ({CHANNELS{duty_on}} & i_Chan_En) ^ INVERT_MASK;
   end

   assign o_Led   = led;
   assign o_Mode  = mode;
   assign o_Level = level;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen.
// The reference model works out the expected level in closed form from the
// number of clock edges since the last load.
module tb_led_pattern_gen;

   localparam int CLK_HZ = 16, TICK_HZ = 4, PWM_BITS = 4, CHANNELS = 2, BLINK_TICKS = 3;
   localparam logic [CHANNELS-1:0] INVERT_MASK = 2'b10;
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PER = 1 << PWM_BITS;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [1:0]          mode_in = 2'd0;
   logic [PWM_BITS-1:0] bright_in = '0;
   logic                load = 1'b0;
   logic [CHANNELS-1:0] en = 2'b11;
   logic [CHANNELS-1:0] led;
   logic [1:0]          mode_out;
   logic [PWM_BITS-1:0] level_out;

   int n_checks = 0;
   int n_fail   = 0;

   led_pattern_gen #(
      .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .PWM_BITS(PWM_BITS), .CHANNELS(CHANNELS),
      .BLINK_TICKS(BLINK_TICKS), .INVERT_MASK(INVERT_MASK)
   ) dut (
      .i_Clk(clk), .i_Rst(rst), .i_Mode(mode_in), .i_Brightness(bright_in),
      .i_Load(load), .i_Chan_En(en), .o_Led(led), .o_Mode(mode_out), .o_Level(level_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Expected level from mode, brightness and the clock edges since the load
   function automatic int exp_level(input int m, input int b, input int t);
      int k;
      int p;
      k = t / DIV;
      case (m)
         0: return 0;
         1: return b;
         2: return (((k / BLINK_TICKS) % 2) == 0) ? b : 0;
         default: begin
            p = k % (2 * b + 2);
            return (p <= b) ? p : (2 * b + 1 - p);
         end
      endcase
   endfunction

   int                  m_mode, m_b, m_t;
   logic [CHANNELS-1:0] m_led;

   // Reference model state
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode <= 0; m_b <= 0; m_t <= 0; m_led <= INVERT_MASK;
      end else begin
         m_led <= ({CHANNELS{(m_t % PER) < exp_level(m_mode, m_b, m_t)}} & en) ^ INVERT_MASK;
         if (load) begin
            m_mode <= int'(mode_in); m_b <= int'(bright_in); m_t <= 0;
         end else begin
            m_t <= m_t + 1;
         end
      end
   end

   // Compare the DUT against the model on every falling edge
   always @(negedge clk) begin
      check("model_mode",  int'(mode_out),  m_mode);
      check("model_level", int'(level_out), exp_level(m_mode, m_b, m_t));
      check("model_led",   int'(led),       int'(m_led));
   end

   task automatic do_load(input logic [1:0] m, input int b);
      @(negedge clk);
      load = 1'b1; mode_in = m; bright_in = PWM_BITS'(b);
      @(negedge clk);
      load = 1'b0;
   endtask

   initial begin
      int cnt, bad, breathe_exp[9];
      breathe_exp = '{1, 2, 3, 3, 2, 1, 0, 0, 1};

      // Reset state, then idle after release without a load
      repeat (2) @(negedge clk);
      check("rst_led", int'(led), 2);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("idle_led", int'(led), 2);
      check("idle_level", int'(level_out), 0);

      // ON, brightness 4
      do_load(2'd1, 4);
      check("on4_level", int'(level_out), 4);
      cnt = 0; bad = 0;
      for (int i = 0; i < PER; i++) begin
         @(negedge clk);
         if (led[0]) cnt++;
         if (led[1] == led[0]) bad++;
      end
      check("on4_high", cnt, 4);
      check("on4_ch1_inv", bad, 0);
      @(negedge clk); en = 2'b01;
      @(negedge clk);
      cnt = 0;
      for (int i = 0; i < PER; i++) begin
         @(negedge clk);
         if (led[1]) cnt++;
      end
      check("dis_ch1_idle", cnt, PER);
      en = 2'b11;

      // BLINK, brightness 15
      do_load(2'd2, 15);
      cnt = 0; bad = 0;
      for (int t = 0; t < 36; t++) begin
         if (int'(level_out) != (((t / 12) % 2 == 0) ? 15 : 0)) bad++;
         if (t >= 13 && t <= 24 && led[0]) cnt++;
         @(negedge clk);
      end
      check("blink_seq", bad, 0);
      check("blink_off_led", cnt, 0);

      // BREATHE, brightness 3: one sample per tick
      do_load(2'd3, 3);
      for (int j = 0; j < 9; j++) begin
         repeat (DIV) @(negedge clk);
         check("breathe_step", int'(level_out), breathe_exp[j]);
      end

      // BREATHE, brightness 0
      do_load(2'd3, 0);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (level_out != 0) bad++;
      end
      check("breathe0", bad, 0);

      // Reload to ON 7 while BREATHE sits at level 2
      do_load(2'd3, 3);
      repeat (2 * DIV) @(negedge clk);
      check("reload_pre", int'(level_out), 2);
      do_load(2'd1, 7);
      check("reload_level", int'(level_out), 7);
      bad = 0;
      for (int t = 1; t <= PER; t++) begin
         @(negedge clk);
         if (led[0] != (t <= 7)) bad++;
      end
      check("reload_pwm_restart", bad, 0);

      // Reset and load asserted together: reset wins
      @(negedge clk);
      rst = 1'b1; load = 1'b1; mode_in = 2'd1; bright_in = 4'd9;
      @(negedge clk);
      rst = 1'b0; load = 1'b0;
      check("rst_vs_load_mode", int'(mode_out), 0);
      repeat (3) @(negedge clk);
      check("rst_vs_load_level", int'(level_out), 0);

      // ON 15: one dark cycle per PWM period
      do_load(2'd1, 15);
      cnt = 0;
      for (int i = 0; i < PER; i++) begin
         @(negedge clk);
         if (!led[0]) cnt++;
      end
      check("on15_low", cnt, 1);

      // Async reset mid-cycle during BLINK, away from any edge
      do_load(2'd2, 15);
      repeat (2) @(negedge clk);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("async_led", int'(led), 2);
      check("async_mode", int'(mode_out), 0);
      check("async_level", int'(level_out), 0);
      @(negedge clk); rst = 1'b0;
      repeat (8) @(negedge clk);
      check("post_rst_level", int'(level_out), 0);
      check("post_rst_led", int'(led), 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
